modport_ctrl: RTL and testbench
===============================

// Module: modport_ctrl
// PURPOSE
// - Pipeline controller for the 5-stage LC-3 core (fetch/decode/execute/memory/writeback).
// - Issues per-stage enables, the memory-access state sequence, branch-taken and ALU/MEM bypass selects.
// - Watches the decode IR, the execute IR_Exec and the memory handshakes complete_instr/complete_data.
// PARAMETERS
// - none (16-bit LC-3 ISA, fixed)
// PORTS
// clock             in   1   rising-edge clock; one clock
// reset             in   1   asynchronous, active-low reset
// complete_instr    in   1   instruction memory returned Instr_dout this cycle
// complete_data     in   1   data memory access finished this cycle
// IR                in   16  instruction in decode
// IR_Exec           in   16  instruction in execute
// Instr_dout        in   16  instruction being fetched
// psr               in   3   current N,Z,P flags
// NZP               in   3   branch condition field of IR_Exec
// enable_updatePC   out  1   PC register may update
// enable_fetch      out  1   fetch stage active
// enable_decode     out  1   decode stage active
// enable_execute    out  1   execute stage active
// enable_writeback  out  1   register-file write allowed
// mem_state         out  2   0=read, 1=indirect-address read, 2=write, 3=idle
// br_taken          out  1   PC loads target address
// bypass_alu_1/2    out  1   VSR1/VSR2 come from previous aluout
// bypass_mem_1/2    out  1   VSR1/VSR2 come from Mem_Bypass_Val (load data)
// BEHAVIOUR
// - Reset (reset=0, async): enable_updatePC=1, enable_fetch=1, all other enables 0, mem_state=3, br_taken=0, bypasses 0.
// - Reset release: enable_decode rises 1 cycle after fetch, execute 1 after decode, writeback 1 after execute.
// - Fetch wait: no instruction-side progress while complete_instr=0; enable_updatePC/fetch/decode/execute hold, writeback 0.
// - Opcodes: ADD 0001, AND 0101, NOT 1001, LEA 1110, LD 0010, LDR 0110, LDI 1010, ST 0011, STR 0111, STI 1011, BR 0000, JMP 1100.
// - Memory FSM starts on the cycle IR_Exec is a memory op. States and transitions:
//   - LD/LDR: 3->0; LDI: 3->1->0; ST/STR: 3->2; STI: 3->1->2.
//   - Each state is held until complete_data=1; from 0 or 2 the FSM returns to 3.
// - Outputs while mem_state!=3:
//   - updatePC/fetch/decode/execute are 0.
//   - writeback=1 only in state 0 on the complete_data cycle; stores never write back.
// - Control ops:
//   - BR/JMP in IR: updatePC=0 and fetch=0 the next cycle; decode is cleared 1 cycle later (bubble).
//   - When the op reaches IR_Exec, br_taken=|(psr&NZP) for BR and 1 for JMP, for that one cycle only.
//   - updatePC and fetch re-assert the following cycle; normal flow resumes.
// - ALU bypass: IR_Exec is ADD/AND/NOT/LEA and IR_Exec[11:9] matches a source of IR:
//   - bypass_alu_1: IR uses SR1=IR[8:6] (ADD/AND/NOT/LDR/STR/JMP).
//   - bypass_alu_2: IR is ADD/AND with IR[5]=0 and SR2=IR[2:0]; or IR is ST/STR/STI with SR=IR[11:9].
// - MEM bypass: same source-matching rules as the ALU bypass, applied when IR_Exec was a load (LD/LDR/LDI).
//   - Asserted only on the first execute cycle after that load's FSM returns to 3.
// - Bypass priority and gating:
//   - ALU bypass has priority over MEM bypass for the same operand.
//   - All bypasses are 0 when enable_execute=0.
// - Simultaneous events: a pending memory op (IR_Exec) is served before branch resolution. A BR in IR during a mem sequence waits.
// - Reset asserted mid-FSM: mem_state goes to 3 immediately and the in-flight access is discarded.
// - All outputs are registered; no combinational path from complete_* to enables except the fetch-wait hold.
// TESTING
// - Reset low 3 cycles, release -> updatePC=fetch=1, then decode, execute, writeback rise on consecutive cycles.
// - ADD R1,R2,R3 then ADD R4,R1,R1 -> bypass_alu_1=bypass_alu_2=1 for 1 cycle.
// - LDI R2 with complete_data after 2 cycles per access -> mem_state 3,1,1,0,0,3; stages frozen; writeback pulses once.
// - STI -> mem_state 3->1->2->3 and writeback never asserts.
// - BRz, psr=3'b010, NZP=3'b010 -> br_taken=1 for 1 cycle; with psr=3'b100 -> br_taken=0.
// - Assert reset while mem_state=2 -> mem_state=3 and all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/modport_ctrl.sv
// Pipeline controller for the 5-stage LC-3 core: stage enables, memory-access
// sequencing, branch resolution and ALU/MEM operand bypass selects.
module modport_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [15:0] Instr_dout,
  input  logic [2:0]  psr,
  input  logic [2:0]  NZP,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] S_READ  = 2'd0;
  localparam logic [1:0] S_IND   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_IDLE  = 2'd3;

  localparam logic [1:0] BR_IDLE    = 2'd0;
  localparam logic [1:0] BR_RESOLVE = 2'd1;
  localparam logic [1:0] BR_REFILL  = 2'd2;

  logic       r_en_updatepc, r_en_fetch, r_en_decode, r_en_execute, r_en_writeback;
  logic [1:0] r_mem_state;
  logic       r_mem_store;
  logic       r_mem_done;
  logic [1:0] r_br_phase;
  logic       r_br_taken;
  logic       r_byp_alu_1, r_byp_alu_2, r_byp_mem_1, r_byp_mem_2;

  logic       w_nx_updatepc, w_nx_fetch, w_nx_decode, w_nx_execute, w_nx_writeback;
  logic [1:0] w_nx_mem_state;
  logic       w_nx_mem_store;
  logic       w_nx_mem_done;
  logic [1:0] w_nx_br_phase;
  logic       w_nx_br_taken;
  logic       w_nx_alu_1, w_nx_alu_2, w_nx_mem_1, w_nx_mem_2;

  logic [3:0] w_op_d, w_op_x;
  logic [2:0] w_dst_x;
  logic       w_hit_1, w_hit_2;
  logic       w_x_alu, w_x_load, w_x_store, w_x_mem;
  logic       w_d_ctrl, w_br_cond, w_mem_start;
  logic       w_unused;

  function automatic logic uses_sr1(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {OP_ST, OP_STR, OP_STI};
  endfunction

  assign w_op_d   = IR[15:12];
  assign w_op_x   = IR_Exec[15:12];
  assign w_dst_x  = IR_Exec[11:9];
  assign w_unused = ^{Instr_dout, IR[4:3], IR_Exec[8:0]};

  assign w_hit_1 = uses_sr1(w_op_d) && (IR[8:6] == w_dst_x);
  assign w_hit_2 = (((w_op_d == OP_ADD) || (w_op_d == OP_AND)) && !IR[5] && (IR[2:0] == w_dst_x))
                || (is_store(w_op_d) && (IR[11:9] == w_dst_x));

  assign w_x_alu   = w_op_x inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  assign w_x_load  = w_op_x inside {OP_LD, OP_LDR, OP_LDI};
  assign w_x_store = is_store(w_op_x);
  assign w_x_mem   = w_x_load || w_x_store;
  assign w_d_ctrl  = (w_op_d == OP_BR) || (w_op_d == OP_JMP);
  assign w_br_cond = (w_op_x == OP_JMP) || ((w_op_x == OP_BR) && (|(psr & NZP)));

  // Memory handshake: the FSM presents a request by leaving S_IDLE and holds the
  // current state until complete_data=1 is sampled on a rising edge, which both
  // acknowledges that access and advances the state in the same edge.
  // r_mem_done blocks a restart while the finished op still sits in IR_Exec.
  assign w_mem_start = (r_mem_state == S_IDLE) && r_en_execute && !r_mem_done
                    && (r_br_phase == BR_IDLE) && w_x_mem;

  always_comb begin
    w_nx_updatepc  = r_en_updatepc;
    w_nx_fetch     = r_en_fetch;
    w_nx_decode    = r_en_decode;
    w_nx_execute   = r_en_execute;
    w_nx_writeback = r_en_writeback;
    w_nx_mem_state = r_mem_state;
    w_nx_mem_store = r_mem_store;
    w_nx_mem_done  = r_mem_done;
    w_nx_br_phase  = r_br_phase;
    w_nx_br_taken  = 1'b0;
    w_nx_alu_1     = r_byp_alu_1;
    w_nx_alu_2     = r_byp_alu_2;
    w_nx_mem_1     = r_byp_mem_1;
    w_nx_mem_2     = r_byp_mem_2;

    if (r_mem_state != S_IDLE) begin
      w_nx_writeback = 1'b0;
      w_nx_alu_1     = 1'b0;
      w_nx_alu_2     = 1'b0;
      w_nx_mem_1     = 1'b0;
      w_nx_mem_2     = 1'b0;
      if (complete_data) begin
        if (r_mem_state == S_IND) begin
          w_nx_mem_state = r_mem_store ? S_WRITE : S_READ;
        end else begin
          w_nx_mem_state = S_IDLE;
          w_nx_updatepc  = 1'b1;
          w_nx_fetch     = 1'b1;
          w_nx_decode    = 1'b1;
          w_nx_execute   = 1'b1;
          w_nx_writeback = (r_mem_state == S_READ);
          w_nx_mem_done  = 1'b1;
          w_nx_mem_1     = (r_mem_state == S_READ) && w_hit_1;
          w_nx_mem_2     = (r_mem_state == S_READ) && w_hit_2;
        end
      end
    end else if (w_mem_start) begin
      if (w_x_store) begin
        w_nx_mem_state = (w_op_x == OP_STI) ? S_IND : S_WRITE;
      end else begin
        w_nx_mem_state = (w_op_x == OP_LDI) ? S_IND : S_READ;
      end
      w_nx_mem_store = w_x_store;
      w_nx_updatepc  = 1'b0;
      w_nx_fetch     = 1'b0;
      w_nx_decode    = 1'b0;
      w_nx_execute   = 1'b0;
      w_nx_writeback = 1'b0;
      w_nx_alu_1     = 1'b0;
      w_nx_alu_2     = 1'b0;
      w_nx_mem_1     = 1'b0;
      w_nx_mem_2     = 1'b0;
    end else if (!complete_instr) begin
      w_nx_writeback = 1'b0;
    end else begin
      w_nx_decode    = r_en_fetch;
      w_nx_execute   = r_en_decode;
      w_nx_writeback = r_en_execute;
      w_nx_mem_done  = 1'b0;
      case (r_br_phase)
        BR_IDLE: begin
          if (r_en_decode && w_d_ctrl) begin
            w_nx_updatepc = 1'b0;
            w_nx_fetch    = 1'b0;
            w_nx_br_phase = BR_RESOLVE;
          end
        end
        BR_RESOLVE: begin
          // Branch op is now in execute; the instruction behind it becomes a bubble.
          w_nx_br_taken = w_br_cond;
          w_nx_decode   = 1'b0;
          w_nx_br_phase = BR_REFILL;
        end
        default: begin
          w_nx_updatepc = 1'b1;
          w_nx_fetch    = 1'b1;
          w_nx_br_phase = BR_IDLE;
        end
      endcase
      w_nx_alu_1 = w_nx_execute && w_x_alu && w_hit_1;
      w_nx_alu_2 = w_nx_execute && w_x_alu && w_hit_2;
      w_nx_mem_1 = 1'b0;
      w_nx_mem_2 = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_en_updatepc  <= 1'b1;
      r_en_fetch     <= 1'b1;
      r_en_decode    <= 1'b0;
      r_en_execute   <= 1'b0;
      r_en_writeback <= 1'b0;
      r_mem_state    <= S_IDLE;
      r_mem_store    <= 1'b0;
      r_mem_done     <= 1'b0;
      r_br_phase     <= BR_IDLE;
      r_br_taken     <= 1'b0;
      r_byp_alu_1    <= 1'b0;
      r_byp_alu_2    <= 1'b0;
      r_byp_mem_1    <= 1'b0;
      r_byp_mem_2    <= 1'b0;
    end else begin
      r_en_updatepc  <= w_nx_updatepc;
      r_en_fetch     <= w_nx_fetch;
      r_en_decode    <= w_nx_decode;
      r_en_execute   <= w_nx_execute;
      r_en_writeback <= w_nx_writeback;
      r_mem_state    <= w_nx_mem_state;
      r_mem_store    <= w_nx_mem_store;
      r_mem_done     <= w_nx_mem_done;
      r_br_phase     <= w_nx_br_phase;
      r_br_taken     <= w_nx_br_taken;
      r_byp_alu_1    <= w_nx_alu_1;
      r_byp_alu_2    <= w_nx_alu_2;
      r_byp_mem_1    <= w_nx_mem_1;
      r_byp_mem_2    <= w_nx_mem_2;
    end
  end

  assign enable_updatePC  = r_en_updatepc;
  assign enable_fetch     = r_en_fetch;
  assign enable_decode    = r_en_decode;
  assign enable_execute   = r_en_execute;
  assign enable_writeback = r_en_writeback;
  assign mem_state        = r_mem_state;
  assign br_taken         = r_br_taken;
  assign bypass_alu_1     = r_byp_alu_1;
  assign bypass_alu_2     = r_byp_alu_2;
  assign bypass_mem_1     = r_byp_mem_1;
  assign bypass_mem_2     = r_byp_mem_2;

endmodule

// File: tb/tb_modport_ctrl.sv
// Directed bench for modport_ctrl. Outputs are packed as
// {updPC,fetch,decode,execute,writeback, mem_state[1:0], br_taken, alu1,alu2,mem1,mem2}.
module tb_modport_ctrl;

  localparam logic [15:0] IDLE_D = 16'h1020;  // ADD R0,R0,#0
  localparam logic [15:0] IDLE_X = 16'h1A20;  // ADD R5,R0,#0

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        complete_instr = 1'b1;
  logic        complete_data = 1'b0;
  logic [15:0] IR = IDLE_D;
  logic [15:0] IR_Exec = IDLE_X;
  logic [15:0] Instr_dout = 16'h0000;
  logic [2:0]  psr = 3'b000;
  logic [2:0]  NZP = 3'b000;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic [1:0]  mem_state;
  logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;

  int n_total = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];

  modport_ctrl dut (
    .clock(clock), .reset(reset),
    .complete_instr(complete_instr), .complete_data(complete_data),
    .IR(IR), .IR_Exec(IR_Exec), .Instr_dout(Instr_dout),
    .psr(psr), .NZP(NZP),
    .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .mem_state(mem_state),
    .br_taken(br_taken),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2)
  );

  // clock / reset
  always #5 clock = ~clock;

  function automatic logic [11:0] outs();
    return {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
            mem_state, br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] ir, input logic [15:0] irx);
    IR = ir;
    IR_Exec = irx;
  endtask

  task automatic step(input string tag, input logic [11:0] exp);
    exp_q.push_back(exp);
    tick();
    chk(tag, outs(), exp_q.pop_front());
  endtask

  task automatic do_branch(input string tag, input logic [15:0] instr,
                           input logic [2:0] p, input logic [2:0] nzp, input logic exp_br);
    drive(instr, IDLE_X);
    step({tag, "_issue"}, 12'b00111_11_0_0000);
    drive(IDLE_D, instr);
    psr = p;
    NZP = nzp;
    step({tag, "_resolve"}, {5'b00011, 2'b11, exp_br, 4'b0000});
    // ALU hit while execute is off must not raise a bypass
    drive(16'h1841, 16'h1283);
    step({tag, "_refill"}, 12'b11001_11_0_0000);
    drive(IDLE_D, IDLE_X);
    step({tag, "_dec"}, 12'b11100_11_0_0000);
    step({tag, "_ex"}, 12'b11110_11_0_0000);
    step({tag, "_full"}, 12'b11111_11_0_0000);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset", outs(), 12'b11000_11_0_0000);
    reset = 1'b1;
    step("fill_dec", 12'b11100_11_0_0000);
    step("fill_ex", 12'b11110_11_0_0000);
    step("fill_wb", 12'b11111_11_0_0000);

    drive(16'h1841, 16'h1283);
    step("byp_both", 12'b11111_11_0_1100);
    drive(16'h1861, 16'h1283);
    step("byp_imm", 12'b11111_11_0_1000);
    drive(16'h3200, 16'h1283);
    step("byp_st", 12'b11111_11_0_0100);
    drive(IDLE_D, IDLE_X);
    step("byp_none", 12'b11111_11_0_0000);

    complete_instr = 1'b0;
    step("fwait", 12'b11110_11_0_0000);
    complete_instr = 1'b1;
    step("fwait_end", 12'b11111_11_0_0000);

    drive(16'h16A0, 16'hA400);
    complete_data = 1'b0;
    step("ldi_start", 12'b00000_01_0_0000);
    step("ldi_ind_w", 12'b00000_01_0_0000);
    complete_data = 1'b1;
    step("ldi_rd", 12'b00000_00_0_0000);
    complete_data = 1'b0;
    step("ldi_rd_w", 12'b00000_00_0_0000);
    complete_data = 1'b1;
    step("ldi_done", 12'b11111_11_0_0010);
    complete_data = 1'b0;
    step("ldi_norestart", 12'b11111_11_0_0000);
    drive(IDLE_D, IDLE_X);

    drive(IDLE_D, 16'hB600);
    complete_data = 1'b1;
    step("sti_start", 12'b00000_01_0_0000);
    step("sti_wr", 12'b00000_10_0_0000);
    step("sti_done", 12'b11110_11_0_0000);
    drive(IDLE_D, IDLE_X);
    complete_data = 1'b0;
    step("sti_after", 12'b11111_11_0_0000);

    do_branch("brz_t", 16'h0400, 3'b010, 3'b010, 1'b1);
    do_branch("brz_n", 16'h0400, 3'b100, 3'b010, 1'b0);
    do_branch("jmp", 16'hC080, 3'b000, 3'b000, 1'b1);

    drive(IDLE_D, 16'h3200);
    step("st_start", 12'b00000_10_0_0000);
    step("st_wait", 12'b00000_10_0_0000);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst", outs(), 12'b11000_11_0_0000);
    drive(IDLE_D, IDLE_X);
    tick();
    chk("rst_hold", outs(), 12'b11000_11_0_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
